// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: FSM states, latched bundle, bubble.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int MS_DATA_W = 16;
  localparam int MS_REG_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Everything MEM/WB needs from the instruction, held while memory is busy.
  typedef struct packed {
    logic                 regWrite;
    logic [1:0]           resultSrc;
    logic [MS_REG_W-1:0]  rd;
    logic [MS_DATA_W-1:0] aluRes;
    logic [MS_DATA_W-1:0] wdata;
    logic                 isLoad;
  } bundle_t;

  // A bubble writes nothing and carries all-zero fields.
  localparam bundle_t BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the stage and the memory.
// Latency: n/a (wires only).
// Backpressure: request is held by the master until the slave pulses ack.
interface mem_access_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = MS_DATA_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_access_stage_timeout_counter.sv
// Counts cycles an access waits for ack; flags the cycle that exhausts the budget.
// Latency: o_done is combinational in the TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module mem_timeout_counter
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  logic [TO_W-1:0] r_count;

  // Count enabled wait cycles; clear between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // The current wait cycle is the TIMEOUT-th one when TIMEOUT-1 have already elapsed.
  assign o_done = i_enable && (r_count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: passes non-memory ops through, drives data memory for loads/stores.
// Latency: 0 cycles pass-through; loads/stores take 3+ cycles (detect, access, response).
// Backpressure: stall holds upstream from the detect cycle until the response cycle.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = MS_DATA_W,
  parameter int REG_W   = MS_REG_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              regWrite_in,
  input  logic [1:0]        resultSrc_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] writeData_in,
  output logic              regWrite_out,
  output logic [1:0]        resultSrc_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] aluRes_out,
  output logic [DATA_W-1:0] readData_out,
  output logic [DATA_W-1:0] writeDataM,
  output logic              stall,
  mem_access_stage_if.master mem,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic              err_illegal,
  output logic [DATA_W-1:0] fault_addr
);

  state_t            r_state;
  state_t            w_state_nxt;
  bundle_t           r_bundle;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err_misalign;
  logic              r_err_timeout;
  logic              r_err_illegal;
  logic [DATA_W-1:0] r_fault_addr;

  logic w_mem_op;
  logic w_illegal;
  logic w_misalign;
  logic w_issue;
  logic w_to_en;
  logic w_to_clr;
  logic w_to_done;
  logic w_stall;

  // Decode the incoming slot; illegal outranks misaligned.
  assign w_mem_op   = valid_in & (memRead_in | memWrite_in);
  assign w_illegal  = w_mem_op & memRead_in & memWrite_in;
  assign w_misalign = w_mem_op & aluRes_in[0] & ~w_illegal;
  assign w_issue    = w_mem_op & ~w_illegal & ~aluRes_in[0];

  // Ack in the same cycle as the last wait cycle wins, so the counter only runs without ack.
  assign w_to_en  = (r_state == ACCESS) & ~mem.mem_ack;
  assign w_to_clr = (r_state != ACCESS);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_to_clr),
    .i_enable (w_to_en),
    .o_done   (w_to_done)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and MEM/WB-facing outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_stall       = 1'b0;
    regWrite_out  = BUBBLE.regWrite;
    resultSrc_out = BUBBLE.resultSrc;
    rd_out        = BUBBLE.rd;
    aluRes_out    = BUBBLE.aluRes;
    readData_out  = '0;
    writeDataM    = BUBBLE.wdata;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          // Memory ops emit a bubble here; only aligned legal ones stall and launch.
          w_stall = w_issue;
          if (w_issue) begin
            w_state_nxt = ACCESS;
          end
        end else begin
          regWrite_out  = regWrite_in & valid_in;
          resultSrc_out = resultSrc_in;
          rd_out        = rd_in;
          aluRes_out    = aluRes_in;
          writeDataM    = writeData_in;
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (mem.mem_ack || w_to_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        regWrite_out  = r_bundle.regWrite;
        resultSrc_out = r_bundle.resultSrc;
        rd_out        = r_bundle.rd;
        aluRes_out    = r_bundle.aluRes;
        readData_out  = r_rdata;
        writeDataM    = r_bundle.wdata;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset must release the upstream immediately, even with a memory op still presented.
  assign stall = w_stall & ~reset;

  // Latch the instruction, hold the memory request, and capture the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bundle    <= BUBBLE;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_bundle    <= '{regWrite: regWrite_in, resultSrc: resultSrc_in, rd: rd_in,
                             aluRes: aluRes_in, wdata: writeData_in, isLoad: memRead_in};
            r_rdata     <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= memWrite_in;
            r_mem_addr  <= aluRes_in;
            r_mem_wdata <= writeData_in;
          end
        end
        ACCESS: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= r_bundle.isLoad ? mem.mem_rdata : '0;
          end else if (w_to_done) begin
            // An abandoned access must not write the register file.
            r_mem_req         <= 1'b0;
            r_rdata           <= '0;
            r_bundle.regWrite <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error flags and the address of the latest fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_fault_addr   <= '0;
    end else if (r_state == IDLE && w_illegal) begin
      r_err_illegal <= 1'b1;
      r_fault_addr  <= aluRes_in;
    end else if (r_state == IDLE && w_misalign) begin
      r_err_misalign <= 1'b1;
      r_fault_addr   <= aluRes_in;
    end else if (r_state == ACCESS && w_to_done) begin
      r_err_timeout <= 1'b1;
      r_fault_addr  <= r_mem_addr;
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign err_misalign  = r_err_misalign;
  assign err_timeout   = r_err_timeout;
  assign err_illegal   = r_err_illegal;
  assign fault_addr    = r_fault_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboarded ops against a responder with programmable ack delay.
// A second instance with a short timeout and a silent memory covers the abort path.
// Outputs sampled 1ns after the falling edge; inputs driven 1ns after the rising edge.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        valid_in, memRead_in, memWrite_in, regWrite_in;
  logic [1:0]  resultSrc_in;
  logic [3:0]  rd_in;
  logic [15:0] aluRes_in, writeData_in;

  logic        regWrite_out, stall, err_misalign, err_timeout, err_illegal;
  logic [1:0]  resultSrc_out;
  logic [3:0]  rd_out;
  logic [15:0] aluRes_out, readData_out, writeDataM, fault_addr;

  logic        regWrite_t, stall_t, err_misalign_t, err_timeout_t, err_illegal_t;
  logic [1:0]  resultSrc_t;
  logic [3:0]  rd_t;
  logic [15:0] aluRes_t, readData_t, writeDataM_t, fault_addr_t;

  mem_access_stage_if #(.DATA_W(16)) mif ();
  mem_access_stage_if #(.DATA_W(16)) mif_t ();

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .regWrite_in(regWrite_in), .resultSrc_in(resultSrc_in),
    .rd_in(rd_in), .aluRes_in(aluRes_in), .writeData_in(writeData_in),
    .regWrite_out(regWrite_out), .resultSrc_out(resultSrc_out), .rd_out(rd_out),
    .aluRes_out(aluRes_out), .readData_out(readData_out), .writeDataM(writeDataM),
    .stall(stall), .mem(mif.master), .err_misalign(err_misalign),
    .err_timeout(err_timeout), .err_illegal(err_illegal), .fault_addr(fault_addr)
  );

  mem_access_stage #(.TIMEOUT(4), .TO_W(8)) dut_to (
    .clk(clk), .reset(reset), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .regWrite_in(regWrite_in), .resultSrc_in(resultSrc_in),
    .rd_in(rd_in), .aluRes_in(aluRes_in), .writeData_in(writeData_in),
    .regWrite_out(regWrite_t), .resultSrc_out(resultSrc_t), .rd_out(rd_t),
    .aluRes_out(aluRes_t), .readData_out(readData_t), .writeDataM(writeDataM_t),
    .stall(stall_t), .mem(mif_t.master), .err_misalign(err_misalign_t),
    .err_timeout(err_timeout_t), .err_illegal(err_illegal_t), .fault_addr(fault_addr_t)
  );

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [3:0]  rd;
    logic [15:0] alu;
    logic [15:0] rdat;
    logic [15:0] wdm;
  } res_t;

  typedef struct {
    res_t res;
    int   cycles;
    int   reqs;
  } exp_t;

  res_t obs_m, obs_t;
  assign obs_m = {regWrite_out, resultSrc_out, rd_out, aluRes_out, readData_out, writeDataM};
  assign obs_t = {regWrite_t, resultSrc_t, rd_t, aluRes_t, readData_t, writeDataM_t};

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Memory responder knobs for the main instance.
  bit          ack_en    = 1'b1;
  int          ack_delay = 0;
  logic [15:0] mem_data  = 16'h0;
  int          wait_cnt  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic rw, input logic [1:0] rs, input logic [3:0] rd,
                              input logic [15:0] alu, input logic [15:0] rdat,
                              input logic [15:0] wdm);
    mk = {rw, rs, rd, alu, rdat, wdm};
  endfunction

  // Ack after ack_delay wait cycles of a held request; the silent memory never acks.
  initial begin
    mif.mem_ack     = 1'b0;
    mif.mem_rdata   = 16'h0;
    mif_t.mem_ack   = 1'b0;
    mif_t.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
      end else if (mif.mem_req && ack_en) begin
        if (wait_cnt == ack_delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem_data;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Present one op, wait for the first non-stalled cycle, then score it.
  task automatic run_op(input string tag, input bit sel, input bit rd_op, input bit wr_op,
                        input bit rw, input logic [1:0] rs, input logic [3:0] rd,
                        input logic [15:0] addr, input logic [15:0] wdat,
                        input res_t exp_res, input int exp_cycles, input int exp_reqs);
    exp_t e;
    int   cyc  = 0;
    int   reqs = 0;
    bit   done = 1'b0;
    valid_in     = 1'b1;
    memRead_in   = rd_op;
    memWrite_in  = wr_op;
    regWrite_in  = rw;
    resultSrc_in = rs;
    rd_in        = rd;
    aluRes_in    = addr;
    writeData_in = wdat;
    e.res    = exp_res;
    e.cycles = exp_cycles;
    e.reqs   = exp_reqs;
    sb.push_back(e);
    while (!done && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
      if (sel ? mif_t.mem_req : mif.mem_req) begin
        reqs++;
        check_eq({tag, ".addr"}, sel ? mif_t.mem_addr : mif.mem_addr, addr);
        check_eq({tag, ".wdata"}, sel ? mif_t.mem_wdata : mif.mem_wdata, wdat);
        check_eq({tag, ".we"}, sel ? mif_t.mem_we : mif.mem_we, wr_op);
      end
      if (!(sel ? stall_t : stall)) done = 1'b1;
    end
    e = sb.pop_front();
    check_eq({tag, ".bundle"}, sel ? obs_t : obs_m, e.res);
    check_eq({tag, ".cycles"}, cyc, e.cycles);
    check_eq({tag, ".req_cycles"}, reqs, e.reqs);
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
    memRead_in  = 1'b0;
    memWrite_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {valid_in, memRead_in, memWrite_in, regWrite_in} = 4'b0;
    resultSrc_in = 2'b0; rd_in = 4'h0; aluRes_in = 16'h0; writeData_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.stall", stall, 0);
    check_eq("rst.mem_req", mif.mem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst.mem_we", mif.mem_we, 0);
    check_eq("rst.mem_addr", mif.mem_addr, 0);
    check_eq("rst.mem_wdata", mif.mem_wdata, 0);
    check_eq("rst.errs", {err_misalign, err_timeout, err_illegal}, 0);
    check_eq("rst.fault_addr", fault_addr, 0);
    check_eq("rst.bundle", obs_m, 0);

    // Invalid slot: fields pass through but nothing is written back.
    regWrite_in = 1'b1; resultSrc_in = 2'd2; rd_in = 4'd9;
    aluRes_in = 16'h5555; writeData_in = 16'h3333;
    #1;
    check_eq("novalid.bundle", obs_m, mk(0, 2'd2, 4'd9, 16'h5555, 16'h0, 16'h3333));
    check_eq("novalid.stall", stall, 0);

    run_op("alu", 0, 0, 0, 1, 2'd0, 4'd5, 16'h1234, 16'h7777,
           mk(1, 2'd0, 4'd5, 16'h1234, 16'h0, 16'h7777), 1, 0);

    ack_delay = 0; mem_data = 16'hBEEF;
    run_op("load0", 0, 1, 0, 1, 2'd1, 4'd3, 16'h0040, 16'h0,
           mk(1, 2'd1, 4'd3, 16'h0040, 16'hBEEF, 16'h0), 3, 1);

    // Store: memory drives junk read data, which must not be captured.
    ack_delay = 4; mem_data = 16'hFFFF;
    run_op("store", 0, 0, 1, 0, 2'd0, 4'd2, 16'h0010, 16'hA5A5,
           mk(0, 2'd0, 4'd2, 16'h0010, 16'h0, 16'hA5A5), 7, 5);

    run_op("misalign", 0, 1, 0, 1, 2'd1, 4'd6, 16'h0041, 16'h0, '0, 1, 0);
    check_eq("misalign.no_req", mif.mem_req, 0);
    check_eq("misalign.flag", err_misalign, 1);
    check_eq("misalign.illegal_flag", err_illegal, 0);
    check_eq("misalign.fault_addr", fault_addr, 16'h0041);

    run_op("illegal", 0, 1, 1, 1, 2'd1, 4'd8, 16'h0020, 16'h0, '0, 1, 0);
    check_eq("illegal.no_req", mif.mem_req, 0);
    check_eq("illegal.flag", err_illegal, 1);
    check_eq("illegal.misalign_sticky", err_misalign, 1);
    check_eq("illegal.fault_addr", fault_addr, 16'h0020);

    ack_delay = 2; mem_data = 16'h1111;
    run_op("load2", 0, 1, 0, 1, 2'd1, 4'd4, 16'h0002, 16'h0,
           mk(1, 2'd1, 4'd4, 16'h0002, 16'h1111, 16'h0), 5, 3);

    // Reset in the middle of an access, with the load still presented.
    ack_en = 1'b0;
    valid_in = 1'b1; memRead_in = 1'b1; regWrite_in = 1'b1; rd_in = 4'd1;
    aluRes_in = 16'h0044; writeData_in = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("midrst.pre_req", mif.mem_req, 1);
    check_eq("midrst.pre_stall", stall, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst.req", mif.mem_req, 0);
    check_eq("midrst.stall", stall, 0);
    check_eq("midrst.errs", {err_misalign, err_timeout, err_illegal}, 0);
    check_eq("midrst.fault_addr", fault_addr, 0);
    check_eq("midrst.bundle", obs_m, 0);
    valid_in = 1'b0; memRead_in = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst_alu", 0, 0, 0, 1, 2'd3, 4'd10, 16'h00F0, 16'h0,
           mk(1, 2'd3, 4'd10, 16'h00F0, 16'h0, 16'h0), 1, 0);

    // Short-timeout instance against a memory that never answers.
    ack_delay = 0; mem_data = 16'h0;
    check_eq("to.pre_flag", err_timeout_t, 0);
    run_op("timeout", 1, 1, 0, 1, 2'd1, 4'd7, 16'h0080, 16'h0,
           mk(0, 2'd1, 4'd7, 16'h0080, 16'h0, 16'h0), 6, 4);
    check_eq("timeout.req_dropped", mif_t.mem_req, 0);
    check_eq("timeout.flag", err_timeout_t, 1);
    check_eq("timeout.fault_addr", fault_addr_t, 16'h0080);
    check_eq("timeout.sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
